// File: rtl/fc_mac_ctrl.sv
// fc_mac_ctrl: sequences weight/input reads and MAC enables for an M x N fully connected layer,
// presenting each finished row through a valid/ready handshake.
module fc_mac_ctrl #(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int P  = 2,
    parameter int WA = (M * N > 1) ? $clog2(M * N) : 1,
    parameter int XA = (N > 1) ? $clog2(N) : 1,
    parameter int RA = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [WA-1:0] w_addr,
    output logic [XA-1:0] x_addr,
    output logic          enable_mult,
    output logic          en_pipeline_reg,
    output logic          en_acc,
    output logic          clear_acc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RA-1:0] out_row
);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, OUT} state_t;

    localparam logic [XA-1:0] COL_LAST = XA'(N - 1);
    localparam logic [RA-1:0] ROW_LAST = RA'(M - 1);
    localparam logic [WA-1:0] ROW_STEP = WA'(N);

    state_t        state, state_nx;
    logic [RA-1:0] row;
    logic [XA-1:0] col;
    logic [WA-1:0] base;
    logic [P:0]    dly;
    logic          done_q;
    logic          hs;

    assign hs = (state == OUT) && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = ISSUE;
            ISSUE:   state_nx = (col == COL_LAST) ? DRAIN : ISSUE;
            // taps below P are still pending products; once clear, the final en_acc is firing now
            DRAIN:   state_nx = (dly[P-1:0] == '0) ? OUT : DRAIN;
            OUT:     state_nx = out_ready ? ((row == ROW_LAST) ? IDLE : CLEAR) : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            base   <= '0;
            dly    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            dly    <= {dly[P-1:0], mem_rd_en};
            done_q <= hs && (row == ROW_LAST);
            if (state == IDLE && start) begin
                row  <= '0;
                base <= '0;
            end
            if (state == CLEAR) col <= '0;
            if (state == ISSUE && col != COL_LAST) col <= col + 1'b1;
            if (hs && row != ROW_LAST) begin
                row  <= row + 1'b1;
                base <= base + ROW_STEP;
            end
        end
    end

    assign busy            = state != IDLE;
    assign enable_mult     = busy;
    assign clear_acc       = state == CLEAR;
    assign mem_rd_en       = state == ISSUE;
    assign w_addr          = mem_rd_en ? base + WA'(col) : '0;
    assign x_addr          = mem_rd_en ? col : '0;
    assign en_pipeline_reg = dly[P-1];
    assign en_acc          = dly[P];
    assign out_valid       = state == OUT;
    assign out_row         = out_valid ? row : '0;
    assign done            = done_q;
endmodule

// File: tb/tb_fc_mac_ctrl.sv
// tb_fc_mac_ctrl: table, directed and random checks of fc_mac_ctrl against a timestamp-based layer model.
module tb_fc_mac_ctrl;
    localparam int M = 2;
    localparam int N = 3;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       reset, start, out_ready;
    logic       busy, done, mem_rd_en, enable_mult, en_pipeline_reg, en_acc, clear_acc, out_valid;
    logic [2:0] w_addr;
    logic [1:0] x_addr;
    logic       out_row;

    logic b_start, b_ready;
    logic b_busy, b_done, b_rd, b_em, b_epr, b_acc, b_clr, b_ov;
    logic b_w, b_x, b_row;

    always #5 clk = ~clk;

    fc_mac_ctrl #(.M(M), .N(N), .P(P)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .w_addr(w_addr), .x_addr(x_addr),
        .enable_mult(enable_mult), .en_pipeline_reg(en_pipeline_reg), .en_acc(en_acc),
        .clear_acc(clear_acc), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row)
    );

    fc_mac_ctrl #(.M(1), .N(1), .P(3)) dut_small (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd), .w_addr(b_w), .x_addr(b_x),
        .enable_mult(b_em), .en_pipeline_reg(b_epr), .en_acc(b_acc),
        .clear_acc(b_clr), .out_valid(b_ov), .out_ready(b_ready), .out_row(b_row)
    );

    typedef struct {
        bit          start;
        bit          ready;
        logic [13:0] e;
    } vec_t;

    vec_t tab[19];
    int   tests = 0;
    int   fails = 0;

    // layer model: each row is described only by the cycle of its clear
    bit act = 0;
    int k = 0, clr = 0, mrow = 0, done_cyc = -1;

    function automatic logic [13:0] pk(bit b, bit dn, bit rd, bit epr, bit acc, bit cl, bit ov,
                                       int w, int x, int r);
        return {b, dn, rd, b, epr, acc, cl, ov, 3'(w), 2'(x), 1'(r)};
    endfunction

    function automatic logic [13:0] model_exp();
        int d = k - clr;
        bit dn = (k == done_cyc);
        bit rd = d >= 1 && d <= N;
        bit ov = d >= N + P + 2;
        if (!act) return pk(0, dn, 0, 0, 0, 0, 0, 0, 0, 0);
        return pk(1, dn, rd, d >= P + 1 && d <= N + P, d >= P + 2 && d <= N + P + 1, d == 0, ov,
                  rd ? mrow * N + d - 1 : 0, rd ? d - 1 : 0, ov ? mrow : 0);
    endfunction

    task automatic tick(input bit s, input bit r, input bit rs, input bit use_tab,
                        input logic [13:0] t);
        logic [13:0] got, exp;
        int d;
        start = s; out_ready = r; reset = rs;
        #4;
        exp = model_exp();
        got = {busy, done, mem_rd_en, enable_mult, en_pipeline_reg, en_acc, clear_acc, out_valid,
               w_addr, x_addr, out_row};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model cyc=%0d got=%h exp=%h", k, got, exp);
        end
        if (use_tab) begin
            tests++;
            if (got !== t) begin
                fails++;
                $display("FAIL table cyc=%0d got=%h exp=%h", k, got, t);
            end
        end
        d = k - clr;
        @(posedge clk);
        if (rs) begin
            act = 0;
            done_cyc = -1;
        end else if (!act) begin
            if (s) begin act = 1; mrow = 0; clr = k + 1; end
        end else if (d >= N + P + 2 && r) begin
            if (mrow == M - 1) begin act = 0; done_cyc = k + 1; end
            else begin mrow++; clr = k + 1; end
        end
        k++;
        #1;
    endtask

    initial begin
        tab[0]  = '{1, 1, pk(0,0,0,0,0,0,0,0,0,0)};
        tab[1]  = '{0, 1, pk(1,0,0,0,0,1,0,0,0,0)};
        tab[2]  = '{0, 1, pk(1,0,1,0,0,0,0,0,0,0)};
        tab[3]  = '{0, 1, pk(1,0,1,0,0,0,0,1,1,0)};
        tab[4]  = '{0, 1, pk(1,0,1,1,0,0,0,2,2,0)};
        tab[5]  = '{0, 1, pk(1,0,0,1,1,0,0,0,0,0)};
        tab[6]  = '{0, 1, pk(1,0,0,1,1,0,0,0,0,0)};
        tab[7]  = '{0, 1, pk(1,0,0,0,1,0,0,0,0,0)};
        tab[8]  = '{0, 1, pk(1,0,0,0,0,0,1,0,0,0)};
        tab[9]  = '{0, 1, pk(1,0,0,0,0,1,0,0,0,0)};
        tab[10] = '{0, 1, pk(1,0,1,0,0,0,0,3,0,0)};
        tab[11] = '{0, 1, pk(1,0,1,0,0,0,0,4,1,0)};
        tab[12] = '{0, 1, pk(1,0,1,1,0,0,0,5,2,0)};
        tab[13] = '{0, 1, pk(1,0,0,1,1,0,0,0,0,0)};
        tab[14] = '{0, 1, pk(1,0,0,1,1,0,0,0,0,0)};
        tab[15] = '{0, 1, pk(1,0,0,0,1,0,0,0,0,0)};
        tab[16] = '{0, 1, pk(1,0,0,0,0,0,1,0,0,1)};
        tab[17] = '{0, 1, pk(0,1,0,0,0,0,0,0,0,0)};
        tab[18] = '{0, 1, pk(0,0,0,0,0,0,0,0,0,0)};

        reset = 1; start = 0; out_ready = 0; b_start = 0; b_ready = 0;
        @(posedge clk);
        #1;
        tick(0, 0, 1, 0, '0);
        tick(0, 1, 0, 0, '0);
        for (int i = 0; i < 19; i++) tick(tab[i].start, tab[i].ready, 0, 1, tab[i].e);

        // reset on the third ISSUE cycle, then a fresh layer must replay the table
        tick(1, 1, 0, 0, '0);
        repeat (3) tick(0, 1, 0, 0, '0);
        tick(0, 1, 1, 0, '0);
        tick(0, 1, 0, 0, '0);
        for (int i = 0; i < 19; i++) tick(tab[i].start, tab[i].ready, 0, 1, tab[i].e);

        // start held high throughout, consumer stalls 5 extra cycles on each row
        tick(1, 0, 0, 0, '0);
        repeat (N + P + 7) tick(1, 0, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        repeat (N + P + 7) tick(1, 0, 0, 0, '0);
        repeat (3) tick(1, 1, 0, 0, '0);
        repeat (4) tick(0, 1, 0, 0, '0);

        repeat (1500)
            tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0, 0, '0);
        repeat (30) tick(0, 1, 0, 0, '0);

        // M=1, N=1, P=3 corner: single issue, longer pipeline, 2-cycle stall
        for (int c = 0; c < 13; c++) begin
            logic [10:0] got, exp;
            b_start = (c == 0);
            b_ready = (c >= 9);
            #4;
            exp = {c >= 1 && c <= 9, c == 10, c == 2, c >= 1 && c <= 9, c == 5, c == 6, c == 1,
                   c >= 7 && c <= 9, 3'b000};
            got = {b_busy, b_done, b_rd, b_em, b_epr, b_acc, b_clr, b_ov, b_w, b_x, b_row};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL small cyc=%0d got=%h exp=%h", c, got, exp);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
